// File: rtl/gen_step_sched.sv
// Generation scheduler: turns evolve ticks / manual steps into a row sweep of the
// update engine and commits each generation with a vblank-aligned buffer swap.
// Optional row watchdog: define GEN_SCHED_WDOG_EN.
module gen_step_sched #(
   parameter int ROWS  = 32,
   parameter int ROW_W = 5,
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             envolve_v,
   input  logic             step_btn,
   input  logic             clear_req,
   input  logic             vblank,
   output logic             row_start,
   output logic             row_clr,
   output logic [ROW_W-1:0] row_idx,
   input  logic             row_done,
   output logic             swap_buf,
   output logic [GEN_W-1:0] gen_count,
   output logic             busy,
`ifdef GEN_SCHED_WDOG_EN
   output logic             wdog_err,
`endif
   output logic             pending
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

   state_t           state, state_n;
   logic [ROW_W-1:0] row_cnt, row_cnt_n;
   logic [GEN_W-1:0] gen_n;
   logic             clr_flag, clr_n;
   logic             pend_trig, pend_trig_n;
   logic             pend_clr, pend_clr_n;
   logic             swap;
   logic             trig;

`ifdef GEN_SCHED_WDOG_EN
   logic [7:0]       wdog_cnt, wdog_cnt_n;
   logic             wdog_err_n;
`endif

   assign trig = mode ? envolve_v : step_btn;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         row_cnt   <= '0;
         clr_flag  <= 1'b0;
         pend_trig <= 1'b0;
         pend_clr  <= 1'b0;
         gen_count <= '0;
`ifdef GEN_SCHED_WDOG_EN
         wdog_cnt  <= '0;
         wdog_err  <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         row_cnt   <= row_cnt_n;
         clr_flag  <= clr_n;
         pend_trig <= pend_trig_n;
         pend_clr  <= pend_clr_n;
         gen_count <= gen_n;
`ifdef GEN_SCHED_WDOG_EN
         wdog_cnt  <= wdog_cnt_n;
         wdog_err  <= wdog_err_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      row_cnt_n   = row_cnt;
      clr_n       = clr_flag;
      pend_trig_n = pend_trig;
      pend_clr_n  = pend_clr;
      gen_n       = gen_count;
      swap        = 1'b0;
`ifdef GEN_SCHED_WDOG_EN
      wdog_cnt_n  = wdog_cnt;
      wdog_err_n  = wdog_err;
`endif

      // While busy, requests are only recorded; IDLE dispatch consumes them.
      if (state != IDLE) begin
         if (trig)      pend_trig_n = 1'b1;
         if (clear_req) pend_clr_n  = 1'b1;
      end

      case (state)
         IDLE: begin
            if (clear_req || pend_clr) begin
               state_n     = ISSUE;
               clr_n       = 1'b1;
               row_cnt_n   = '0;
               pend_clr_n  = 1'b0;
               pend_trig_n = trig;
            end else if (trig || pend_trig) begin
               state_n     = ISSUE;
               clr_n       = 1'b0;
               row_cnt_n   = '0;
               pend_trig_n = 1'b0;
            end
         end
         ISSUE: begin
            state_n = WAIT;
`ifdef GEN_SCHED_WDOG_EN
            wdog_cnt_n = '0;
`endif
         end
         WAIT: begin
            if (row_done) begin
               if (row_cnt == ROW_W'(ROWS - 1)) begin
                  state_n = COMMIT;
               end else begin
                  row_cnt_n = row_cnt + 1'b1;
                  state_n   = ISSUE;
               end
            end
`ifdef GEN_SCHED_WDOG_EN
            else begin
               wdog_cnt_n = wdog_cnt + 8'd1;
               // Stalled engine: abandon the sweep when the counter hits 255.
               if (wdog_cnt == 8'd254) begin
                  state_n     = IDLE;
                  row_cnt_n   = '0;
                  pend_trig_n = 1'b0;
                  wdog_err_n  = 1'b1;
               end
            end
`endif
         end
         COMMIT: begin
            if (vblank) begin
               swap      = 1'b1;
               state_n   = IDLE;
               row_cnt_n = '0;
               gen_n     = clr_flag ? '0 : gen_count + 1'b1;
`ifdef GEN_SCHED_WDOG_EN
               if (clr_flag) wdog_err_n = 1'b0;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign row_start = (state == ISSUE);
   assign row_clr   = row_start & clr_flag;
   assign row_idx   = row_cnt;
   assign swap_buf  = swap & ~rst;
   assign busy      = (state != IDLE);
   assign pending   = pend_trig;

endmodule

// File: tb/tb_gen_step_sched.sv
// Directed bench for gen_step_sched: a scoreboard holds expected row issues and
// committed generation values; a small engine model answers each row.
module tb_gen_step_sched;

   localparam int ROWS  = 4;
   localparam int ROW_W = 2;
   localparam int GEN_W = 3;

   logic             clk = 1'b0;
   logic             rst, mode, envolve_v, step_btn, clear_req, vblank, row_done;
   logic             row_start, row_clr, swap_buf, busy, pending;
   logic [ROW_W-1:0] row_idx;
   logic [GEN_W-1:0] gen_count;

   int checks = 0;
   int errors = 0;
   int swap_cnt = 0;

   int               rowq[$];
   logic [GEN_W-1:0] genq[$];
   logic [GEN_W-1:0] mgen = '0;
   logic [2:0]       eng_sr = '0;

   gen_step_sched #(.ROWS(ROWS), .ROW_W(ROW_W), .GEN_W(GEN_W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .envolve_v(envolve_v), .step_btn(step_btn),
      .clear_req(clear_req), .vblank(vblank), .row_start(row_start), .row_clr(row_clr),
      .row_idx(row_idx), .row_done(row_done), .swap_buf(swap_buf), .gen_count(gen_count),
      .busy(busy), .pending(pending)
   );

   always #5 clk = ~clk;

   // Engine answers each row three cycles after its row_start.
   assign row_done = eng_sr[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_sweep(input bit clr);
      for (int r = 0; r < ROWS; r++) rowq.push_back(int'(clr) * 256 + r);
      mgen = clr ? '0 : mgen + 1'b1;
      genq.push_back(mgen);
   endtask

   task automatic drive(input logic ev, input logic st, input logic cl);
      @(posedge clk); #1;
      envolve_v = ev; step_btn = st; clear_req = cl;
      @(posedge clk); #1;
      envolve_v = 1'b0; step_btn = 1'b0; clear_req = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(posedge clk); #1;
         if (!busy && !pending) done = 1'b1;
      end
      chk("idle_timeout", 32'(done), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_row_start"}, 32'(row_start), 0);
      chk({tag, "_row_clr"},   32'(row_clr),   0);
      chk({tag, "_row_idx"},   32'(row_idx),   0);
      chk({tag, "_swap_buf"},  32'(swap_buf),  0);
      chk({tag, "_gen_count"}, 32'(gen_count), 0);
      chk({tag, "_busy"},      32'(busy),      0);
      chk({tag, "_pending"},   32'(pending),   0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         eng_sr = {eng_sr[1:0], row_start};
      end
   end

   // Scoreboard monitor: row issues and generation commits.
   initial begin
      bit gen_due = 1'b0;
      forever begin
         @(negedge clk);
         if (gen_due) begin
            gen_due = 1'b0;
            if (genq.size() == 0) chk("unexpected_swap", 32'd1, 32'd0);
            else chk("gen_count_commit", 32'(gen_count), 32'(genq.pop_front()));
         end
         if (row_start) begin
            if (rowq.size() == 0) chk("unexpected_row_start", 32'(row_idx), 32'hFFFF);
            else chk("row_issue", 32'(int'(row_clr) * 256 + int'(row_idx)), 32'(rowq.pop_front()));
         end
         if (swap_buf) begin
            swap_cnt++;
            gen_due = 1'b1;
         end
      end
   end

   initial begin
      int sw0;
      bit hit;
      rst = 1'b1; mode = 1'b1; envolve_v = 1'b0; step_btn = 1'b0;
      clear_req = 1'b0; vblank = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      rst = 1'b0;

      // Auto run, with trigger-to-row_start latency check.
      exp_sweep(1'b0);
      drive(1'b1, 1'b0, 1'b0);
      chk("latency_row_start", 32'(row_start), 32'd1);
      chk("latency_row_idx", 32'(row_idx), 32'd0);
      wait_idle(60);
      chk("auto_gen", 32'(gen_count), 32'd1);
      chk("auto_busy", 32'(busy), 32'd0);

      // Mode gating: envolve_v ignored in manual mode, step_btn runs.
      mode = 1'b0;
      drive(1'b1, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1 chk("gated_busy", 32'(busy), 32'd0);
      exp_sweep(1'b0);
      drive(1'b0, 1'b1, 1'b0);
      wait_idle(60);
      chk("manual_gen", 32'(gen_count), 32'd2);

      // Queue depth one: three extra ticks mid-sweep give one extra sweep.
      mode = 1'b1;
      exp_sweep(1'b0);
      drive(1'b1, 1'b0, 1'b0);
      exp_sweep(1'b0);
      repeat (3) drive(1'b1, 1'b0, 1'b0);
      chk("queue_pending", 32'(pending), 32'd1);
      wait_idle(100);
      chk("queue_gen", 32'(gen_count), 32'd4);

      // Vblank hold: stays in COMMIT until vblank rises.
      vblank = 1'b0;
      exp_sweep(1'b0);
      drive(1'b1, 1'b0, 1'b0);
      sw0 = swap_cnt;
      repeat (50) @(posedge clk);
      #1 chk("vb_busy", 32'(busy), 32'd1);
      chk("vb_row_idx", 32'(row_idx), 32'(ROWS - 1));
      chk("vb_no_swap", 32'(swap_cnt - sw0), 32'd0);
      vblank = 1'b1;
      #1 chk("vb_swap_now", 32'(swap_buf), 32'd1);
      @(posedge clk); #1;
      chk("vb_idle", 32'(busy), 32'd0);
      chk("vb_gen", 32'(gen_count), 32'd5);

      // Clear beats a same-cycle trigger; the trigger follows as a normal sweep.
      exp_sweep(1'b1);
      exp_sweep(1'b0);
      drive(1'b1, 1'b0, 1'b1);
      chk("clr_row_clr", 32'(row_clr), 32'd1);
      wait_idle(100);
      chk("clr_then_gen", 32'(gen_count), 32'd1);

      // Counter wraps from 2^GEN_W-1 to 0.
      for (int k = 0; k < 7; k++) begin
         exp_sweep(1'b0);
         drive(1'b1, 1'b0, 1'b0);
         wait_idle(60);
      end
      chk("wrap_gen", 32'(gen_count), 32'd0);

      // Reset at row 2 abandons the sweep without a swap.
      exp_sweep(1'b0);
      drive(1'b1, 1'b0, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         if (row_start && row_idx == 2) hit = 1'b1;
      end
      chk("rst_reach_row2", 32'(hit), 32'd1);
      sw0 = swap_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      rowq.delete(); genq.delete(); mgen = '0;
      chk_all_zero("midrst");
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1 chk("midrst_no_swap", 32'(swap_cnt - sw0), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);

      chk("rowq_empty", 32'(rowq.size()), 32'd0);
      chk("genq_empty", 32'(genq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
